user_key_irq: RTL and testbench

//  Parametrised key/switch peripheral: N active-low key pins, each 2-flop synchronised and

---
 rtl/user_key_irq.sv | 97 +++++++++
 tb/tb_user_key_irq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/user_key_irq.sv
// Key/switch peripheral: synchronised, debounced active-low key pins with
// press/release edge capture into sticky pending bits and a level interrupt.
module user_key_irq #(
    parameter int          N_KEYS     = 8,
    parameter int          DEB_CYCLES = 50000,
    parameter int          DEB_W      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_7f40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] user_key,
    input  logic [31:0]       ADD_I,
    input  logic [31:0]       DAT_I,
    input  logic              WE_I,
    output logic [31:0]       DAT_O,
    output logic              IRQ_O
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [29:0]      BASE_W   = BASE_ADDR[31:2];

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] ks;
    logic [N_KEYS-1:0] state_q;
    logic [N_KEYS-1:0] pend_q;
    logic [N_KEYS-1:0] rise_q;
    logic [N_KEYS-1:0] fall_q;
    logic [N_KEYS-1:0] evt;
    logic [N_KEYS-1:0] set_pend;
    logic [N_KEYS-1:0] w1c;
    logic [DEB_W-1:0]  cnt [N_KEYS];

    logic [29:0] rel;
    logic        hit;
    logic [1:0]  off;
    logic        unused_bits;

    // Offset relative to the base word so BASE_ADDR need only be word aligned.
    assign rel = ADD_I[31:2] - BASE_W;
    assign hit = (rel < 30'd4);
    assign off = rel[1:0];
    assign unused_bits = ^{ADD_I[1:0], DAT_I};

    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            evt[i] = (ks[i] != state_q[i]) && (cnt[i] == DEB_LAST);
        end
    end

    assign set_pend = evt & ((ks & rise_q) | (~ks & fall_q));
    assign w1c      = (WE_I && hit && off == 2'd1) ? DAT_I[N_KEYS-1:0] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            ks      <= '0;
            state_q <= '0;
            pend_q  <= '0;
            rise_q  <= '1;
            fall_q  <= '0;
        end else begin
            sync1   <= ~user_key;
            ks      <= sync1;
            state_q <= state_q ^ evt;
            // A new edge event overrides a same-cycle clear.
            pend_q  <= (pend_q & ~w1c) | set_pend;
            if (WE_I && hit && off == 2'd2) rise_q <= DAT_I[N_KEYS-1:0];
            if (WE_I && hit && off == 2'd3) fall_q <= DAT_I[N_KEYS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (ks[i] == state_q[i] || cnt[i] == DEB_LAST) cnt[i] <= '0;
                else                                            cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        DAT_O = '0;
        if (hit) begin
            case (off)
                2'd0:    DAT_O[N_KEYS-1:0] = state_q;
                2'd1:    DAT_O[N_KEYS-1:0] = pend_q;
                2'd2:    DAT_O[N_KEYS-1:0] = rise_q;
                default: DAT_O[N_KEYS-1:0] = fall_q;
            endcase
        end
    end

    assign IRQ_O = |pend_q;

endmodule

// File: tb/tb_user_key_irq.sv
// Directed bench for user_key_irq with a short debounce: register table plus
// hand-written sequences for debounce timing, W1C races and reset corners.
module tb_user_key_irq;

    localparam logic [31:0] A_STATE = 32'h7f40;
    localparam logic [31:0] A_PEND  = 32'h7f44;
    localparam logic [31:0] A_RISE  = 32'h7f48;
    localparam logic [31:0] A_FALL  = 32'h7f4c;
    localparam logic [31:0] IDLE    = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  user_key;
    logic [31:0] ADD_I, DAT_I, DAT_O;
    logic        WE_I, IRQ_O;

    logic [31:0] uk32, dat32;
    logic [31:0] add32 = A_STATE;
    logic [31:0] din32 = '0;
    logic        we32 = 1'b0;
    logic        irq32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    user_key_irq #(.N_KEYS(8), .DEB_CYCLES(4), .DEB_W(3), .BASE_ADDR(32'h7f40)) dut (
        .clk(clk), .reset(reset), .user_key(user_key), .ADD_I(ADD_I), .DAT_I(DAT_I),
        .WE_I(WE_I), .DAT_O(DAT_O), .IRQ_O(IRQ_O)
    );

    user_key_irq #(.N_KEYS(32), .DEB_CYCLES(4), .DEB_W(4), .BASE_ADDR(32'h7f40)) dut32 (
        .clk(clk), .reset(reset), .user_key(uk32), .ADD_I(add32), .DAT_I(din32),
        .WE_I(we32), .DAT_O(dat32), .IRQ_O(irq32)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        ADD_I = a;
        WE_I  = 1'b0;
        #1;
        chk(name, DAT_O, exp);
        ADD_I = IDLE;
    endtask

    task automatic chk_irq(input string name, input logic exp);
        chk(name, {31'b0, IRQ_O}, {31'b0, exp});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ADD_I = a;
        DAT_I = d;
        WE_I  = 1'b1;
        tick();
        WE_I  = 1'b0;
        ADD_I = IDLE;
    endtask

    initial begin
        logic irq_seen;

        vt = '{
            '{A_RISE,        1'b1, 32'h0000_005a, 32'h0},
            '{A_RISE,        1'b0, 32'h0,         32'h0000_005a},
            '{A_FALL,        1'b1, 32'h0000_003c, 32'h0},
            '{A_FALL,        1'b0, 32'h0,         32'h0000_003c},
            '{A_RISE,        1'b1, 32'hffff_ff00, 32'h0},
            '{A_RISE,        1'b0, 32'h0,         32'h0},
            '{A_STATE,       1'b1, 32'hffff_ffff, 32'h0},
            '{A_STATE,       1'b0, 32'h0,         32'h0},
            '{A_PEND,        1'b1, 32'hffff_ffff, 32'h0},
            '{A_PEND,        1'b0, 32'h0,         32'h0},
            '{32'h7f50,      1'b1, 32'h0000_00ff, 32'h0},
            '{32'h7f50,      1'b0, 32'h0,         32'h0},
            '{A_FALL,        1'b0, 32'h0,         32'h0000_003c},
            '{32'h7f3c,      1'b0, 32'h0,         32'h0},
            '{32'h0001_7f48, 1'b0, 32'h0,         32'h0},
            '{A_RISE,        1'b1, 32'h0000_00ff, 32'h0},
            '{A_FALL,        1'b1, 32'h0,         32'h0},
            '{32'h7f4a,      1'b0, 32'h0,         32'h0000_00ff},
            '{A_FALL,        1'b0, 32'h0,         32'h0},
            '{A_PEND,        1'b0, 32'h0,         32'h0}
        };

        reset    = 1'b0;
        user_key = 8'hff;
        uk32     = '1;
        ADD_I    = IDLE;
        DAT_I    = '0;
        WE_I     = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);

        // reset state
        chk_reg("rst_state", A_STATE, 32'h0);
        chk_reg("rst_pend",  A_PEND,  32'h0);
        chk_reg("rst_rise",  A_RISE,  32'hff);
        chk_reg("rst_fall",  A_FALL,  32'h0);
        chk_irq("rst_irq", 1'b0);

        // register map table
        for (int i = 0; i < 20; i++) begin
            if (vt[i].we) begin
                wr(vt[i].addr, vt[i].data);
            end else begin
                chk_reg($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
                tick();
            end
        end

        // key 3 press: accepted on the 6th edge after the pin change
        user_key = 8'hf7;
        tick(5);
        chk_reg("k3_early_state", A_STATE, 32'h0);
        chk_irq("k3_early_irq", 1'b0);
        tick();
        chk_reg("k3_state", A_STATE, 32'h08);
        chk_reg("k3_pend",  A_PEND,  32'h08);
        chk_irq("k3_irq", 1'b1);
        wr(A_PEND, 32'h08);
        chk_reg("k3_clr_pend", A_PEND, 32'h0);
        chk_irq("k3_clr_irq", 1'b0);
        user_key = 8'hff;
        tick(8);
        chk_reg("k3_rel_state", A_STATE, 32'h0);
        chk_reg("k3_rel_pend",  A_PEND,  32'h0);

        // glitches of 3 cycles never pass a 4-cycle debounce
        irq_seen = 1'b0;
        for (int r = 0; r < 5; r++) begin
            user_key = 8'hfe;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (IRQ_O) irq_seen = 1'b1;
            end
            user_key = 8'hff;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (IRQ_O) irq_seen = 1'b1;
            end
        end
        tick(4);
        chk_reg("glitch_state", A_STATE, 32'h0);
        chk_reg("glitch_pend",  A_PEND,  32'h0);
        chk("glitch_irq_seen", {31'b0, irq_seen}, 32'h0);

        // release-only enable
        wr(A_FALL, 32'h01);
        wr(A_RISE, 32'h00);
        user_key = 8'hfe;
        tick(10);
        chk_reg("fall_press_state", A_STATE, 32'h01);
        chk_reg("fall_press_pend",  A_PEND,  32'h0);
        chk_irq("fall_press_irq", 1'b0);
        user_key = 8'hff;
        tick(10);
        chk_reg("fall_rel_state", A_STATE, 32'h0);
        chk_reg("fall_rel_pend",  A_PEND,  32'h01);
        chk_irq("fall_rel_irq", 1'b1);
        wr(A_PEND, 32'h01);
        wr(A_RISE, 32'hff);
        wr(A_FALL, 32'h00);
        chk_irq("fall_clr_irq", 1'b0);

        // W1C on the same edge as the key 2 press event: set wins
        user_key = 8'hfb;
        tick(5);
        chk_reg("race_pre_pend", A_PEND, 32'h0);
        wr(A_PEND, 32'h04);
        chk_reg("race_state", A_STATE, 32'h04);
        chk_reg("race_pend",  A_PEND,  32'h04);
        chk_irq("race_irq", 1'b1);
        wr(A_RISE, 32'h00);
        chk_reg("dis_keeps_pend", A_PEND, 32'h04);
        wr(A_PEND, 32'h04);
        chk_reg("race_clr_pend", A_PEND, 32'h0);
        wr(A_RISE, 32'hff);
        user_key = 8'hff;
        tick(10);

        // reset mid-debounce (count at 2), key still held afterwards
        user_key = 8'hdf;
        tick(4);
        reset = 1'b0;
        #1;
        chk_irq("mid_rst_irq", 1'b0);
        tick();
        reset = 1'b1;
        chk_reg("mid_rst_state", A_STATE, 32'h0);
        chk_reg("mid_rst_pend",  A_PEND,  32'h0);
        chk_reg("mid_rst_rise",  A_RISE,  32'hff);
        chk_reg("unmapped_rd",   32'h7f50, 32'h0);
        tick(5);
        chk_reg("held_early_state", A_STATE, 32'h0);
        tick();
        chk_reg("held_state", A_STATE, 32'h20);
        chk_reg("held_pend",  A_PEND,  32'h20);
        chk_irq("held_irq", 1'b1);
        wr(A_PEND, 32'h20);
        chk_irq("held_clr_irq", 1'b0);
        user_key = 8'hff;

        // 32-key build: every key pressed
        uk32 = '0;
        tick(5);
        chk("k32_early_state", dat32, 32'h0);
        tick();
        chk("k32_state", dat32, 32'hffff_ffff);
        chk("k32_irq", {31'b0, irq32}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
